and3_share_encoder: RTL



---
 rtl/masking_pkg.sv | 29 ++
 rtl/lfsr16.sv | 32 +++
 rtl/and3_share_encoder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/masking_pkg.sv
// Shared types and constants for the two-share AND3 masking front end.
// LFSR polynomial, randomness width and the encoder FSM encoding live here.
package masking_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GATHER,
        OUT
    } state_t;

    localparam int LFSR_W     = 16;
    localparam int RAND_BITS  = 5;
    localparam int NUM_SHARES = 2;

    localparam logic [LFSR_W-1:0] TAP_MASK = 16'hB400;

    // Mask is in polynomial order (x^16 at the MSB); the register shifts
    // right, so the taps are read from the bit-reversed mask.
    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] v
    );
        logic [LFSR_W-1:0] taps;
        for (int i = 0; i < LFSR_W; i++) begin
            taps[i] = TAP_MASK[LFSR_W-1-i];
        end
        return {^(v & taps), v[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Fibonacci LFSR with seed load.
// Never holds zero: a zero seed is replaced by 16'h0001.
module lfsr16
    import masking_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed,
    output logic              lsb
);

    localparam logic [LFSR_W-1:0] RST_VAL =
        (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= RST_VAL;
        end else if (seed_valid) begin
            lfsr <= (seed == '0) ? LFSR_W'(1) : seed;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    assign lsb = lfsr[0];

endmodule

// File: rtl/and3_share_encoder.sv
// Splits a, b, c into two Boolean shares and supplies gadget refresh bits.
// Optional sticky share self-check enabled by SHARE_SELFCHECK_EN (adds o_err).
module and3_share_encoder
    import masking_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              i_a,
    input  logic              i_b,
    input  logic              i_c,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              o_a0,
    output logic              o_a1,
    output logic              o_b0,
    output logic              o_b1,
    output logic              o_c0,
    output logic              o_c1,
    output logic              o_rN0,
    output logic              o_rN1
`ifdef SHARE_SELFCHECK_EN
    ,
    output logic              o_err
`endif
);

    localparam logic [2:0] LAST_IDX = 3'(RAND_BITS - 1);

    state_t                 state;
    state_t                 nxt;
    logic   [2:0]           cnt;
    logic   [RAND_BITS-1:0] rnd;
    logic   [RAND_BITS-1:0] rnd_sh;
    logic                   a_l;
    logic                   b_l;
    logic                   c_l;
    logic                   lsb;
    logic                   last;

    lfsr16 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .seed_valid(seed_valid),
        .seed      (seed),
        .lsb       (lsb)
    );

    assign in_ready  = (state == IDLE) & ~rst;
    assign out_valid = (state == OUT);
    assign last      = (state == GATHER) && (cnt == LAST_IDX);

    always_comb begin
        rnd_sh      = rnd;
        rnd_sh[cnt] = lsb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (in_valid) nxt = GATHER;
            GATHER:  if (last) nxt = OUT;
            OUT:     if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            rnd   <= '0;
            a_l   <= 1'b0;
            b_l   <= 1'b0;
            c_l   <= 1'b0;
            o_a0  <= 1'b0;
            o_a1  <= 1'b0;
            o_b0  <= 1'b0;
            o_b1  <= 1'b0;
            o_c0  <= 1'b0;
            o_c1  <= 1'b0;
            o_rN0 <= 1'b0;
            o_rN1 <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_l <= i_a;
                b_l <= i_b;
                c_l <= i_c;
                cnt <= '0;
            end
            if (state == GATHER) begin
                rnd <= rnd_sh;
                cnt <= cnt + 3'd1;
            end
            // The fifth bit is taken straight from the shift, not from rnd.
            if (last) begin
                o_a0  <= a_l ^ rnd_sh[0];
                o_a1  <= rnd_sh[0];
                o_b0  <= b_l ^ rnd_sh[1];
                o_b1  <= rnd_sh[1];
                o_c0  <= c_l ^ rnd_sh[2];
                o_c1  <= rnd_sh[2];
                o_rN0 <= rnd_sh[3];
                o_rN1 <= rnd_sh[4];
            end
        end
    end

`ifdef SHARE_SELFCHECK_EN
    logic chk;
    logic bad;

    assign bad = ((o_a0 ^ o_a1) != a_l)
               | ((o_b0 ^ o_b1) != b_l)
               | ((o_c0 ^ o_c1) != c_l);

    always_ff @(posedge clk) begin
        if (rst) begin
            chk   <= 1'b0;
            o_err <= 1'b0;
        end else begin
            chk <= last;
            if (chk && bad) begin
                o_err <= 1'b1;
            end
        end
    end
`endif

endmodule
